// File: rtl/mem_ctrl_arb_pkg.sv
// rtl/mem_ctrl_arb_pkg.sv - shared types and helpers for the fetch/memory RAM controller
// Purpose: FSM state encoding, request owner codes, read/write codes and the
//          beat-counter width helper used by mem_ctrl_arb and its arbiter.
// Ports:   none (package).
package mem_ctrl_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BEAT = 2'd1,
    ST_DONE = 2'd2
  } mc_state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } mc_owner_e;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  // A single-beat configuration still needs a 1-bit beat field in the RAM address.
  function automatic int beat_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/mem_ctrl_arb_rr_arbiter.sv
// rtl/mem_ctrl_arb_rr_arbiter.sv - two-requester arbiter (fixed priority or round-robin)
// Purpose: picks IF or MEM when the controller is idle.
// Ports:   clock, reset (async, active-low)
//          req_if, req_mem   request lines
//          accept            controller consumes the grant this cycle
//          grant_valid       at least one request present
//          grant_owner       winning port
module mem_ctrl_arb_rr_arbiter
  import mem_ctrl_arb_pkg::*;
#(
  parameter int ARB_MODE = 0
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      req_if,
  input  logic      req_mem,
  input  logic      accept,
  output logic      grant_valid,
  output mc_owner_e grant_owner
);

  logic prefer_mem;
  logic contended;

  assign contended   = req_if & req_mem;
  assign grant_valid = req_if | req_mem;

  always_comb begin
    grant_owner = OWN_IF;
    if (contended) begin
      if ((ARB_MODE == 0) || prefer_mem) grant_owner = OWN_MEM;
    end else if (req_mem) begin
      grant_owner = OWN_MEM;
    end
  end

  // Pointer moves only when both ports competed, so a lone requester never
  // steals the other port's next turn.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prefer_mem <= 1'b1;
    end else if (accept && contended) begin
      prefer_mem <= (grant_owner == OWN_IF);
    end
  end

endmodule

// File: rtl/mem_ctrl_arb.sv
// rtl/mem_ctrl_arb.sv - IF/MEM arbitrated controller for a narrow external RAM
// Purpose: grants one pipeline port at a time, splits the DATA_W word into
//          DATA_W/RAM_W RAM beats (LS slice first), returns a one-cycle ready.
// Ports:   clock, reset (async, active-low)
//          if_mc_en/if_mc_addr -> mc_if_data/mc_if_ready          fetch (read-only)
//          mem_mc_en/rw/addr/wdata -> mc_mem_rdata/mc_mem_ready   memory stage
//          mc_ram_addr/wre/oe/wdata, mc_ram_rdata                 external RAM
module mem_ctrl_arb
  import mem_ctrl_arb_pkg::*;
#(
  parameter  int ADDR_W   = 18,
  parameter  int DATA_W   = 32,
  parameter  int RAM_W    = 16,
  parameter  int ARB_MODE = 0,
  localparam int BEATS    = DATA_W / RAM_W,
  localparam int BEAT_W   = beat_width(BEATS),
  localparam int RA_W     = ADDR_W + BEAT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_mc_en,
  input  logic [ADDR_W-1:0] if_mc_addr,
  output logic [DATA_W-1:0] mc_if_data,
  output logic              mc_if_ready,
  input  logic              mem_mc_en,
  input  logic              mem_mc_rw,
  input  logic [ADDR_W-1:0] mem_mc_addr,
  input  logic [DATA_W-1:0] mem_mc_wdata,
  output logic [DATA_W-1:0] mc_mem_rdata,
  output logic              mc_mem_ready,
  output logic [RA_W-1:0]   mc_ram_addr,
  output logic              mc_ram_wre,
  output logic              mc_ram_oe,
  output logic [RAM_W-1:0]  mc_ram_wdata,
  input  logic [RAM_W-1:0]  mc_ram_rdata
);

  mc_state_e         state;
  logic [BEAT_W-1:0] beat;
  logic [BEAT_W-1:0] beat_next;
  logic              last_beat;
  mc_owner_e         owner_q;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rd_buf;
  logic [DATA_W-1:0] rd_buf_nxt;

  logic              grant_valid;
  mc_owner_e         grant_owner;
  logic [ADDR_W-1:0] g_addr;
  logic              g_rw;

  mem_ctrl_arb_rr_arbiter #(.ARB_MODE(ARB_MODE)) u_arb (
    .clock       (clock),
    .reset       (reset),
    .req_if      (if_mc_en),
    .req_mem     (mem_mc_en),
    .accept      (state == ST_IDLE),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  // Fetch is always a read regardless of what the MEM port drives.
  always_comb begin
    g_addr = if_mc_addr;
    g_rw   = RW_READ;
    if (grant_owner == OWN_MEM) begin
      g_addr = mem_mc_addr;
      g_rw   = mem_mc_rw;
    end
  end

  assign beat_next = beat + 1'b1;
  assign last_beat = (beat == BEAT_W'(BEATS - 1));

  // Buffer including the beat arriving at this edge, so the final word can be
  // published on the same edge that closes the last beat.
  always_comb begin
    rd_buf_nxt = rd_buf;
    rd_buf_nxt[int'(beat)*RAM_W +: RAM_W] = mc_ram_rdata;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      beat         <= '0;
      owner_q      <= OWN_IF;
      rw_q         <= RW_READ;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_buf       <= '0;
      mc_if_data   <= '0;
      mc_if_ready  <= 1'b0;
      mc_mem_rdata <= '0;
      mc_mem_ready <= 1'b0;
      mc_ram_addr  <= '0;
      mc_ram_wre   <= 1'b0;
      mc_ram_oe    <= 1'b0;
      mc_ram_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            owner_q      <= grant_owner;
            rw_q         <= g_rw;
            addr_q       <= g_addr;
            wdata_q      <= mem_mc_wdata;
            beat         <= '0;
            mc_ram_addr  <= {g_addr, {BEAT_W{1'b0}}};
            mc_ram_wre   <= (g_rw == RW_WRITE);
            mc_ram_oe    <= (g_rw == RW_WRITE);
            mc_ram_wdata <= (g_rw == RW_WRITE) ? mem_mc_wdata[RAM_W-1:0] : '0;
            state        <= ST_BEAT;
          end
        end
        ST_BEAT: begin
          if (rw_q == RW_READ) rd_buf <= rd_buf_nxt;
          if (last_beat) begin
            beat         <= '0;
            mc_ram_addr  <= '0;
            mc_ram_wre   <= 1'b0;
            mc_ram_oe    <= 1'b0;
            mc_ram_wdata <= '0;
            state        <= ST_DONE;
            if (owner_q == OWN_MEM) begin
              mc_mem_ready <= 1'b1;
              if (rw_q == RW_READ) mc_mem_rdata <= rd_buf_nxt;
            end else begin
              mc_if_ready <= 1'b1;
              mc_if_data  <= rd_buf_nxt;
            end
          end else begin
            beat         <= beat_next;
            mc_ram_addr  <= {addr_q, beat_next};
            mc_ram_wdata <= (rw_q == RW_WRITE) ? wdata_q[int'(beat_next)*RAM_W +: RAM_W] : '0;
          end
        end
        ST_DONE: begin
          mc_if_ready  <= 1'b0;
          mc_mem_ready <= 1'b0;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl_arb.sv
// tb/tb_mem_ctrl_arb.sv - self-checking bench for mem_ctrl_arb (32-bit fixed, 64-bit round-robin)
module tb_mem_ctrl_arb;
  localparam int BUDGET = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT a: defaults (32/16, fixed priority)
  logic        a_if_en = 0, a_mem_en = 0, a_mem_rw = 0;
  logic [17:0] a_if_addr = 0, a_mem_addr = 0;
  logic [31:0] a_mem_wdata = 0, a_if_data, a_mem_rdata;
  logic        a_if_ready, a_mem_ready, a_ram_wre, a_ram_oe;
  logic [18:0] a_ram_addr;
  logic [15:0] a_ram_wdata, a_ram_rdata = 0;

  // DUT b: 64/16 (4 beats), round-robin
  logic        b_if_en = 0, b_mem_en = 0, b_mem_rw = 0;
  logic [17:0] b_if_addr = 0, b_mem_addr = 0;
  logic [63:0] b_mem_wdata = 0, b_if_data, b_mem_rdata;
  logic        b_if_ready, b_mem_ready, b_ram_wre, b_ram_oe;
  logic [19:0] b_ram_addr;
  logic [15:0] b_ram_wdata, b_ram_rdata = 0;

  mem_ctrl_arb dut_a (
    .clock(clk), .reset(rst_n),
    .if_mc_en(a_if_en), .if_mc_addr(a_if_addr), .mc_if_data(a_if_data), .mc_if_ready(a_if_ready),
    .mem_mc_en(a_mem_en), .mem_mc_rw(a_mem_rw), .mem_mc_addr(a_mem_addr), .mem_mc_wdata(a_mem_wdata),
    .mc_mem_rdata(a_mem_rdata), .mc_mem_ready(a_mem_ready),
    .mc_ram_addr(a_ram_addr), .mc_ram_wre(a_ram_wre), .mc_ram_oe(a_ram_oe),
    .mc_ram_wdata(a_ram_wdata), .mc_ram_rdata(a_ram_rdata)
  );

  mem_ctrl_arb #(.ADDR_W(18), .DATA_W(64), .RAM_W(16), .ARB_MODE(1)) dut_b (
    .clock(clk), .reset(rst_n),
    .if_mc_en(b_if_en), .if_mc_addr(b_if_addr), .mc_if_data(b_if_data), .mc_if_ready(b_if_ready),
    .mem_mc_en(b_mem_en), .mem_mc_rw(b_mem_rw), .mem_mc_addr(b_mem_addr), .mem_mc_wdata(b_mem_wdata),
    .mc_mem_rdata(b_mem_rdata), .mc_mem_ready(b_mem_ready),
    .mc_ram_addr(b_ram_addr), .mc_ram_wre(b_ram_wre), .mc_ram_oe(b_ram_oe),
    .mc_ram_wdata(b_ram_wdata), .mc_ram_rdata(b_ram_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Half-word RAM models: write on the edge, read data presented mid-cycle.
  logic [15:0] ram_a [int];
  logic [15:0] ram_b [int];
  int wre_seen_a = 0;

  always @(posedge clk) begin
    if (a_ram_wre) ram_a[int'(a_ram_addr)] = a_ram_wdata;
    if (b_ram_wre) ram_b[int'(b_ram_addr)] = b_ram_wdata;
  end

  always @(negedge clk) begin
    a_ram_rdata = ram_a.exists(int'(a_ram_addr)) ? ram_a[int'(a_ram_addr)] : 16'h0;
    b_ram_rdata = ram_b.exists(int'(b_ram_addr)) ? ram_b[int'(b_ram_addr)] : 16'h0;
    if (a_ram_wre) wre_seen_a++;
    if (rst_n) begin
      chk("a_oe_eq_wre", a_ram_oe, a_ram_wre);
      chk("b_oe_eq_wre", b_ram_oe, b_ram_wre);
    end
  end

  // Word-level reference memory for the randomized phase.
  logic [31:0] ref_mem [int];
  function automatic logic [31:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  // One transaction on DUT a; starts and ends at a falling edge with the DUT idle.
  task automatic txn_a(input bit is_mem, input bit rw, input logic [17:0] addr,
                       input logic [31:0] wdata, output logic [31:0] data, output int lat);
    lat  = -1;
    data = 'x;
    if (is_mem) begin
      a_mem_en = 1; a_mem_rw = rw; a_mem_addr = addr; a_mem_wdata = wdata;
    end else begin
      a_if_en = 1; a_if_addr = addr;
    end
    for (int c = 1; c <= BUDGET; c++) begin
      @(negedge clk);
      if (is_mem ? a_mem_ready : a_if_ready) begin
        lat  = c;
        data = is_mem ? a_mem_rdata : a_if_data;
        break;
      end
    end
    a_if_en = 0; a_mem_en = 0;
    @(negedge clk);
    chk("ready_one_cycle", is_mem ? a_mem_ready : a_if_ready, 1'b0);
  endtask

  // Simultaneous IF read and MEM op on DUT a; each en dropped at its own ready.
  task automatic both_a(input bit mrw, input logic [17:0] maddr, input logic [31:0] mwd,
                        input logic [17:0] iaddr, output logic [31:0] md, output logic [31:0] id,
                        output int tm, output int ti);
    tm = -1; ti = -1; md = 'x; id = 'x;
    a_mem_en = 1; a_mem_rw = mrw; a_mem_addr = maddr; a_mem_wdata = mwd;
    a_if_en = 1; a_if_addr = iaddr;
    for (int c = 1; c <= BUDGET; c++) begin
      @(negedge clk);
      if (a_mem_ready) begin tm = c; md = a_mem_rdata; a_mem_en = 0; end
      if (a_if_ready) begin ti = c; id = a_if_data; a_if_en = 0; end
      if (tm > 0 && ti > 0) break;
    end
    a_mem_en = 0; a_if_en = 0;
    @(negedge clk);
  endtask

  typedef struct {
    bit          is_mem;
    bit          rw;
    logic [17:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;    // port read data at ready (writes: retained MEM read value)
  } vec_t;

  vec_t        vecs[9];
  logic [31:0] d, md, id, exp_m, exp_i, wd, last_mem;
  logic [63:0] w5, bd;
  logic [17:0] ma, ia;
  int          lat, tm, ti, pulses, tfirst, wre_before, nrd, kind;
  bit          mrw;
  bit          own[4];
  int          tim[4];

  initial begin
    vecs[0] = '{1, 0, 18'h00100, 32'h12345678, 32'h0};
    vecs[1] = '{1, 0, 18'h00101, 32'hCAFEF00D, 32'h0};
    vecs[2] = '{0, 1, 18'h00100, 32'h0,        32'h12345678};
    vecs[3] = '{1, 1, 18'h00101, 32'h0,        32'hCAFEF00D};
    vecs[4] = '{1, 0, 18'h3FFFF, 32'hFFFF0001, 32'hCAFEF00D};
    vecs[5] = '{0, 1, 18'h3FFFF, 32'h0,        32'hFFFF0001};
    vecs[6] = '{1, 0, 18'h00000, 32'hA5A55A5A, 32'hCAFEF00D};
    vecs[7] = '{1, 1, 18'h00000, 32'h0,        32'hA5A55A5A};
    vecs[8] = '{0, 1, 18'h00101, 32'h0,        32'hCAFEF00D};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_a_ready", {a_if_ready, a_mem_ready}, 2'b00);
    chk("rst_a_ram", {a_ram_addr, a_ram_wre, a_ram_oe, a_ram_wdata}, 0);
    chk("rst_a_data", {a_if_data, a_mem_rdata}, 0);
    chk("rst_b_ram", {b_ram_addr, b_ram_wre, b_ram_oe, b_ram_wdata, b_if_ready, b_mem_ready}, 0);
    rst_n = 1;
    @(negedge clk);

    // Table vectors
    for (int i = 0; i < 9; i++) begin
      txn_a(vecs[i].is_mem, vecs[i].rw, vecs[i].addr, vecs[i].wdata, d, lat);
      chk($sformatf("vec%0d_latency", i), lat, 3);
      chk($sformatf("vec%0d_data", i), d, vecs[i].exp);
    end

    // Beat-level view of a MEM write
    a_mem_en = 1; a_mem_rw = 0; a_mem_addr = 18'h00010; a_mem_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("w_beat0", {a_ram_addr, a_ram_wdata, a_ram_wre, a_ram_oe}, {19'h00020, 16'hBEEF, 2'b11});
    chk("w_beat0_noready", a_mem_ready, 1'b0);
    @(negedge clk);
    chk("w_beat1", {a_ram_addr, a_ram_wdata, a_ram_wre, a_ram_oe}, {19'h00021, 16'hDEAD, 2'b11});
    @(negedge clk);
    chk("w_ready", {a_mem_ready, a_ram_wre}, 2'b10);
    a_mem_en = 0;
    @(negedge clk);
    chk("w_ready_drop", a_mem_ready, 1'b0);

    // IF read back: no RAM writes during a read
    wre_before = wre_seen_a;
    txn_a(0, 1, 18'h00010, 0, d, lat);
    chk("if_rd_data", d, 32'hDEADBEEF);
    chk("if_rd_latency", lat, 3);
    chk("if_rd_no_wre", wre_seen_a, wre_before);

    // MEM read with en dropped after grant still completes once
    pulses = 0; tfirst = -1; d = 'x;
    a_mem_en = 1; a_mem_rw = 1; a_mem_addr = 18'h00010;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) a_mem_en = 0;
      if (a_mem_ready) begin pulses++; if (tfirst < 0) begin tfirst = c; d = a_mem_rdata; end end
    end
    chk("drop_en_pulses", pulses, 1);
    chk("drop_en_time", tfirst, 3);
    chk("drop_en_data", d, 32'hDEADBEEF);

    // Fixed priority under contention: MEM write lands before IF reads it
    for (int i = 0; i < 5; i++) begin
      wd = $urandom;
      both_a(0, 18'h00040 + 18'(i), wd, 18'h00040 + 18'(i), md, id, tm, ti);
      chk($sformatf("prio%0d_mem_time", i), tm, 3);
      chk($sformatf("prio%0d_if_time", i), ti, 7);
      chk($sformatf("prio%0d_if_data", i), id, wd);
    end

    // 64-bit, 4-beat write with beat addresses {addr, 2'b00..2'b11}
    w5 = 64'h0123456789ABCDEF;
    b_mem_en = 1; b_mem_rw = 0; b_mem_addr = 18'h00007; b_mem_wdata = w5;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("b_beat%0d", c - 1), {b_ram_addr, b_ram_wdata, b_ram_wre},
          {20'h0001C + 20'(c - 1), w5[16*(c-1) +: 16], 1'b1});
    end
    @(negedge clk);
    chk("b_w_ready", b_mem_ready, 1'b1);
    b_mem_en = 0;
    @(negedge clk);
    chk("b_w_ready_drop", b_mem_ready, 1'b0);

    tfirst = -1; bd = 'x;
    b_if_en = 1; b_if_addr = 18'h00007;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (b_if_ready && tfirst < 0) begin tfirst = c; bd = b_if_data; b_if_en = 0; end
    end
    b_if_en = 0;
    chk("b_rd_latency", tfirst, 5);
    chk("b_rd_data", bd, w5);

    // Round-robin with both ports requesting continuously
    nrd = 0;
    b_mem_en = 1; b_mem_rw = 1; b_mem_addr = 18'h00007; b_if_en = 1; b_if_addr = 18'h00007;
    for (int c = 1; c <= 60 && nrd < 4; c++) begin
      @(negedge clk);
      if (b_mem_ready && nrd < 4) begin
        own[nrd] = 1; tim[nrd] = c; nrd++;
        chk("rr_mem_data", b_mem_rdata, w5);
      end
      if (b_if_ready && nrd < 4) begin
        own[nrd] = 0; tim[nrd] = c; nrd++;
        chk("rr_if_data", b_if_data, w5);
      end
    end
    b_mem_en = 0; b_if_en = 0;
    chk("rr_count", nrd, 4);
    for (int k = 0; k < 4 && k < nrd; k++) begin
      chk($sformatf("rr%0d_owner", k), own[k], (k % 2 == 0) ? 1'b1 : 1'b0);
      chk($sformatf("rr%0d_time", k), tim[k], 5 + 6 * k);
    end
    repeat (2) @(negedge clk);

    // Reset during beat 1 of a write
    txn_a(1, 0, 18'h00155, 32'h11112222, d, lat);
    a_mem_en = 1; a_mem_rw = 0; a_mem_addr = 18'h00155; a_mem_wdata = 32'hAAAABBBB;
    @(negedge clk);
    chk("abort_beat0_wre", a_ram_wre, 1'b1);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("abort_outputs", {a_ram_addr, a_ram_wre, a_ram_oe, a_ram_wdata, a_mem_ready, a_if_ready}, 0);
    a_mem_en = 0;
    @(negedge clk);
    rst_n = 1;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (a_mem_ready || a_if_ready) pulses++;
    end
    chk("abort_no_ready", pulses, 0);
    chk("abort_lo_written", ram_a[(32'h155 << 1)], 16'hBBBB);
    chk("abort_hi_kept", ram_a[(32'h155 << 1) | 1], 16'h1111);
    txn_a(0, 1, 18'h00155, 0, d, lat);
    chk("after_abort_data", d, 32'h1111BBBB);
    chk("after_abort_latency", lat, 3);

    // Randomized traffic against a word-level model (MEM wins on contention)
    last_mem = 32'h0;
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 2);
      ma = 18'h00200 + 18'($urandom_range(0, 7));
      ia = 18'h00200 + 18'($urandom_range(0, 7));
      mrw = 1'($urandom_range(0, 1));
      wd = $urandom;
      if (kind == 0) begin
        txn_a(0, 1, ia, 0, d, lat);
        chk("rnd_if_latency", lat, 3);
        chk("rnd_if_data", d, ref_rd(int'(ia)));
      end else if (kind == 1) begin
        txn_a(1, mrw, ma, wd, d, lat);
        chk("rnd_mem_latency", lat, 3);
        if (mrw) last_mem = ref_rd(int'(ma));
        else ref_mem[int'(ma)] = wd;
        chk("rnd_mem_data", d, last_mem);
      end else begin
        both_a(mrw, ma, wd, ia, md, id, tm, ti);
        if (mrw) last_mem = ref_rd(int'(ma));
        else ref_mem[int'(ma)] = wd;
        exp_m = last_mem;
        exp_i = ref_rd(int'(ia));
        chk("rnd_both_mem_time", tm, 3);
        chk("rnd_both_if_time", ti, 7);
        chk("rnd_both_mem_data", md, exp_m);
        chk("rnd_both_if_data", id, exp_i);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
